fb_scanout: RTL and testbench

- Downstream consumer of the sprite drawing engine.
- Once the engine pulses done, this block takes the frame-buffer SRAM read port and reads all WIDTH*HEIGHT 12-bit RGB pixels in raster order.
- Pixels leave on a valid/ready stream with start-of-frame, end-of-line and end-of-frame markers, for the display/serializer stage.
- A 2-entry output buffer absorbs the 1-cycle SRAM read latency under backpressure, so no pixel is lost or duplicated.

---
 rtl/fb_scanout_if.sv | 28 ++
 rtl/fb_scanout.sv | 111 +++++++++++
 tb/tb_fb_scanout.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fb_scanout_if.sv
// Frame-buffer read port plus pixel stream between the scanout block and its neighbours.
// The master side is the scanout block; the slave side is the engine/SRAM/display environment.
interface fb_scanout_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 12
);
    logic              frame_go;
    logic              fb_cen;
    logic [ADDR_W-1:0] fb_a;
    logic [DATA_W-1:0] fb_q;
    logic              pix_valid;
    logic              pix_ready;
    logic [DATA_W-1:0] pix_data;
    logic              pix_sof;
    logic              pix_eol;
    logic              pix_eof;
    logic              busy;
    logic              overrun;

    modport master (
        input  frame_go, fb_q, pix_ready,
        output fb_cen, fb_a, pix_valid, pix_data, pix_sof, pix_eol, pix_eof, busy, overrun
    );
    modport slave (
        output frame_go, fb_q, pix_ready,
        input  fb_cen, fb_a, pix_valid, pix_data, pix_sof, pix_eol, pix_eof, busy, overrun
    );
endinterface

// File: rtl/fb_scanout.sv
// Reads one full frame from the FB SRAM in raster order and streams it out with SOF/EOL/EOF markers.
// A 2-entry buffer covers the 1-cycle SRAM latency so backpressure never drops or repeats a pixel.
module fb_scanout #(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 64,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 12
) (
    input  logic         clk,
    input  logic         reset,
    fb_scanout_if.master bus
);
    localparam logic [ADDR_W:0] LP_N    = (ADDR_W+1)'(WIDTH * HEIGHT);
    localparam logic [ADDR_W:0] LP_LAST = (ADDR_W+1)'(WIDTH * HEIGHT - 1);
    localparam logic [ADDR_W:0] LP_ONE  = (ADDR_W+1)'(1);
    localparam int              XW      = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t            r_state;
    logic [ADDR_W:0]   r_rd_addr;
    logic [ADDR_W:0]   r_out_idx;
    logic              r_inflight;
    logic              r_hd;
    logic [1:0]        r_count;
    logic [DATA_W-1:0] r_buf [2];
    logic              r_fb_cen;
    logic [ADDR_W-1:0] r_fb_a;
    logic              r_busy;
    logic              r_overrun;

    logic              w_valid;
    logic              w_pop;
    logic [1:0]        w_occ;
    logic              w_issue;

    assign w_valid = (r_count != 2'd0);
    assign w_pop   = w_valid & bus.pix_ready;
    // Occupancy after this edge's pop; counting the pop keeps 1 pixel/clock with ready held high.
    assign w_occ   = r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_issue = (r_state == S_RUN) && (r_rd_addr < LP_N) && (w_occ < 2'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_rd_addr  <= '0;
            r_out_idx  <= '0;
            r_inflight <= 1'b0;
            r_hd       <= 1'b0;
            r_count    <= 2'd0;
            r_buf[0]   <= '0;
            r_buf[1]   <= '0;
            r_fb_cen   <= 1'b1;
            r_fb_a     <= '0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_fb_cen   <= ~w_issue;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fb_a    <= r_rd_addr[ADDR_W-1:0];
                r_rd_addr <= r_rd_addr + LP_ONE;
            end
            // Tail slot is computed from pre-pop state; a same-edge pop only moves the head.
            if (r_inflight)
                r_buf[r_hd ^ r_count[0]] <= bus.fb_q;
            if (w_pop) begin
                r_hd      <= ~r_hd;
                r_out_idx <= r_out_idx + LP_ONE;
            end
            r_count <= w_occ;

            case (r_state)
                S_IDLE: begin
                    if (bus.frame_go) begin
                        r_busy    <= 1'b1;
                        r_rd_addr <= '0;
                        r_out_idx <= '0;
                        r_overrun <= 1'b0;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.frame_go)
                        r_overrun <= 1'b1;
                    if (w_issue && r_rd_addr == LP_LAST)
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (bus.frame_go)
                        r_overrun <= 1'b1;
                    if (w_pop && r_out_idx == LP_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.fb_cen    = r_fb_cen;
    assign bus.fb_a      = r_fb_a;
    assign bus.pix_valid = w_valid;
    assign bus.pix_data  = r_buf[r_hd];
    assign bus.pix_sof   = w_valid && (r_out_idx == '0);
    assign bus.pix_eol   = w_valid && (&r_out_idx[XW-1:0]);
    assign bus.pix_eof   = w_valid && (r_out_idx == LP_LAST);
    assign bus.busy      = r_busy;
    assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout: each accepted frame_go queues the expected pixel stream,
// and a negedge monitor checks pixels, read addresses, read-ahead depth and stall stability.
module tb_fb_scanout;
    localparam int N = 4096;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fb_scanout_if #(.ADDR_W(12), .DATA_W(12)) bus();

    fb_scanout #(.WIDTH(64), .HEIGHT(64), .ADDR_W(12), .DATA_W(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // SRAM model: data for the registered address is presented the cycle after it is driven.
    logic [11:0] mem [N];
    assign bus.fb_q = mem[bus.fb_a];

    int checks = 0;
    int failures = 0;
    int rd_cnt = 0;
    int acc_cnt = 0;
    int rdy_mode = 0;
    logic [14:0] q [$];
    logic        st_flag = 1'b0;
    logic [14:0] st_val = '0;

    task automatic chk(input string nm, input int got, input int expv);
        checks++;
        if (got != expv) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, expv, $time);
        end
    endtask

    // Ready driver: 0 = held high, 1 = random 50%, 2 = held low.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: bus.pix_ready = 1'b1;
            1: bus.pix_ready = 1'($urandom_range(0, 1));
            default: bus.pix_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        logic [14:0] cur;
        logic [14:0] e;
        cur = {bus.pix_data, bus.pix_sof, bus.pix_eol, bus.pix_eof};
        if (reset) begin
            st_flag = 1'b0;
        end else begin
            if (st_flag)
                chk("stall_hold", {15'd0, bus.pix_valid, cur}, {15'd0, 1'b1, st_val});
            if (!bus.fb_cen) begin
                chk("rd_addr", int'(bus.fb_a), rd_cnt);
                rd_cnt++;
                chk("readahead_le2", int'(rd_cnt - acc_cnt <= 2), 1);
            end
            if (bus.pix_valid && bus.pix_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_pix", int'(cur), -1);
                end else begin
                    e = q.pop_front();
                    chk("pixel", int'(cur), int'(e));
                end
                acc_cnt++;
            end
            st_flag = bus.pix_valid && !bus.pix_ready;
            st_val  = cur;
        end
    end

    task automatic pulse_go();
        @(posedge clk); #1 bus.frame_go = 1'b1;
        @(posedge clk); #1 bus.frame_go = 1'b0;
    endtask

    task automatic start_frame();
        rd_cnt = 0;
        acc_cnt = 0;
        for (int i = 0; i < N; i++)
            q.push_back({mem[i], 1'(i == 0), 1'(i % 64 == 63), 1'(i == N - 1)});
        pulse_go();
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (bus.busy && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_timeout"}, int'(bus.busy), 0);
        repeat (4) @(posedge clk);
        #1;
        chk({nm, "_drained"}, q.size(), 0);
        chk({nm, "_reads"}, rd_cnt, N);
        chk({nm, "_cen_idle"}, int'(bus.fb_cen), 1);
    endtask

    task automatic wait_acc(input int target, input string nm);
        int n;
        n = 0;
        while (acc_cnt < target && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_reached"}, int'(acc_cnt >= target), 1);
    endtask

    initial begin
        bus.frame_go = 1'b0;
        bus.pix_ready = 1'b1;
        for (int i = 0; i < N; i++) mem[i] = 12'(i);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cen", int'(bus.fb_cen), 1);
        chk("rst_fb_a", int'(bus.fb_a), 0);
        chk("rst_valid", int'(bus.pix_valid), 0);
        chk("rst_data", int'(bus.pix_data), 0);
        chk("rst_marks", int'({bus.pix_sof, bus.pix_eol, bus.pix_eof}), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_overrun", int'(bus.overrun), 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Frame A: ready high, latency and first-pixel markers
        rdy_mode = 0;
        start_frame();
        chk("A_busy_after_go", int'(bus.busy), 1);
        chk("A_valid_t0", int'(bus.pix_valid), 0);
        @(posedge clk); #1;
        chk("A_cen_t1", int'(bus.fb_cen), 0);
        chk("A_addr_t1", int'(bus.fb_a), 0);
        chk("A_valid_t1", int'(bus.pix_valid), 0);
        @(posedge clk); #1;
        chk("A_valid_t2", int'(bus.pix_valid), 1);
        chk("A_sof_t2", int'(bus.pix_sof), 1);
        chk("A_data_t2", int'(bus.pix_data), 0);
        wait_idle("A");

        // Frame B: random backpressure
        rdy_mode = 1;
        start_frame();
        wait_idle("B");

        // Frame C: second go mid-frame is ignored and flags overrun
        start_frame();
        wait_acc(100, "C_px100");
        pulse_go();
        chk("C_overrun_set", int'(bus.overrun), 1);
        wait_idle("C");
        chk("C_overrun_sticky", int'(bus.overrun), 1);

        // Frame D: new go clears overrun, then reset aborts mid-frame
        start_frame();
        chk("D_overrun_clr", int'(bus.overrun), 0);
        wait_acc(2000, "D_px2000");
        @(posedge clk); #3 reset = 1'b1;
        #1;
        chk("D_rst_valid", int'(bus.pix_valid), 0);
        chk("D_rst_cen", int'(bus.fb_cen), 1);
        chk("D_rst_busy", int'(bus.busy), 0);
        q.delete();
        @(posedge clk); #3 reset = 1'b0;
        repeat (2) @(posedge clk);

        // Frame E: ready low for 20 cycles, only two reads may be outstanding
        rdy_mode = 2;
        start_frame();
        repeat (20) @(posedge clk);
        #2;
        chk("E_two_reads", rd_cnt, 2);
        chk("E_cen_hold", int'(bus.fb_cen), 1);
        chk("E_head_sof", int'({bus.pix_valid, bus.pix_sof}), 3);
        chk("E_head_data", int'(bus.pix_data), 0);
        rdy_mode = 0;
        wait_idle("E");

        // Frame F: boundary pixels
        mem[0] = 12'h123;
        mem[N-1] = 12'hABC;
        start_frame();
        @(posedge clk); @(posedge clk); #2;
        chk("F_first", int'({bus.pix_data, bus.pix_sof}), int'({12'h123, 1'b1}));
        wait_acc(N - 1, "F_px4095");
        while (!bus.pix_valid && bus.busy) begin
            @(posedge clk); #2;
        end
        chk("F_eof_data", int'(bus.pix_data), 12'hABC);
        chk("F_eof_marks", int'({bus.pix_sof, bus.pix_eol, bus.pix_eof}), 3);
        chk("F_busy_at_eof", int'(bus.busy), 1);
        @(posedge clk); #1;
        chk("F_busy_after_eof", int'(bus.busy), 0);
        wait_idle("F");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
